// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder sequencer around one shared full_adder
// Operands are loaded on a start/ready handshake and added LSB first, one bit per clock.

module full_adder (
   input  logic x,
   input  logic y,
   input  logic carry_in,
   output logic s,
   output logic carry_out
);
   assign s         = x ^ y ^ carry_in;
   assign carry_out = (x & y) | (carry_in & (x ^ y));
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             done
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic [WIDTH-1:0] sum_next;
   logic [CW-1:0]    cnt;
   logic             carry_q;
   logic             fa_s;
   logic             fa_co;

   full_adder u_fa (
      .x         (a_sh[0]),
      .y         (b_sh[0]),
      .carry_in  (carry_q),
      .s         (fa_s),
      .carry_out (fa_co)
   );

   // Shift form keeps WIDTH=1 legal: the new bit lands in bit WIDTH-1.
   assign sum_next = (sum_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ready   <= 1'b1;
         done    <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
         cnt     <= '0;
         carry_q <= 1'b0;
         a_sh    <= '0;
         b_sh    <= '0;
         sum_sh  <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh    <= a;
                  b_sh    <= b;
                  carry_q <= cin;
                  cnt     <= '0;
                  ready   <= 1'b0;
                  state   <= RUN;
               end
            end
            RUN: begin
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               sum_sh  <= sum_next;
               carry_q <= fa_co;
               cnt     <= cnt + CW'(1);
               if (cnt == LAST) begin
                  sum   <= sum_next;
                  cout  <= fa_co;
                  done  <= 1'b1;
                  state <= FIN;
               end
            end
            FIN: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed self-checking bench for serial_add_ctrl
// Covers WIDTH=8 handshake/latency/reset cases, WIDTH=4 exhaustive and WIDTH=1.

module tb_serial_add_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic       cin = 1'b0;
   logic       ready, cout, done;
   logic [7:0] sum;

   logic       start4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       cin4 = 1'b0;
   logic       ready4, cout4, done4;
   logic [3:0] sum4;

   logic       start1 = 1'b0;
   logic [0:0] a1 = '0, b1 = '0;
   logic       cin1 = 1'b0;
   logic       ready1, cout1, done1;
   logic [0:0] sum1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
      .ready(ready), .sum(sum), .cout(cout), .done(done)
   );

   serial_add_ctrl #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
      .ready(ready4), .sum(sum4), .cout(cout4), .done(done4)
   );

   serial_add_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .ready(ready1), .sum(sum1), .cout(cout1), .done(done1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One WIDTH=8 add from an idle DUT: checks latency, held result, one-cycle done.
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                         input logic [7:0] exp_sum, input logic exp_cout);
      int         lat;
      logic [7:0] prev;
      prev = sum;
      a = ta; b = tb_; cin = tc; start = 1'b1;
      tick();
      start = 1'b0;
      a = ~ta; b = ~tb_; cin = ~tc;
      check("accept_ready_low", {31'd0, ready}, 32'd0);
      lat = 0;
      while (lat < 20) begin
         tick();
         lat++;
         if (done) break;
         if (sum !== prev) check("sum_held_in_run", {24'd0, sum}, {24'd0, prev});
      end
      check("latency", lat, 8);
      check("sum", {24'd0, sum}, {24'd0, exp_sum});
      check("cout", {31'd0, cout}, {31'd0, exp_cout});
      check("ready_in_done", {31'd0, ready}, 32'd0);
      tick();
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("ready_after", {31'd0, ready}, 32'd1);
   endtask

   initial begin
      logic [8:0] exp_q[$];
      logic [8:0] e9;
      logic [4:0] e5;
      int         last_acc, cyc, n_done, lat;
      logic       acc;

      // Reset from power-up
      tick(); tick();
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_sum", {24'd0, sum}, 32'd0);
      check("rst_cout", {31'd0, cout}, 32'd0);
      rst = 1'b0;
      tick();

      run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
      run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
      run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
      run_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0);

      // Reset mid-RUN: rst sampled at the 3rd RUN edge
      a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrun_rst_ready", {31'd0, ready}, 32'd1);
      check("midrun_rst_sum", {24'd0, sum}, 32'd0);
      check("midrun_rst_cout", {31'd0, cout}, 32'd0);
      n_done = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done) n_done++;
      end
      check("midrun_no_done", n_done, 0);

      // rst and start on the same edge: rst wins
      a = 8'h12; b = 8'h34; start = 1'b1; rst = 1'b1;
      tick();
      start = 1'b0; rst = 1'b0;
      tick();
      check("rst_start_not_accepted", {31'd0, ready}, 32'd1);

      // start held high with operands changing every cycle
      last_acc = -1; n_done = 0;
      start = 1'b1;
      for (cyc = 0; cyc < 62; cyc++) begin
         if (cyc == 50) start = 1'b0;
         a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
         acc = ready & start;
         e9 = {1'b0, a} + {1'b0, b} + {8'd0, cin};
         tick();
         if (acc) begin
            exp_q.push_back(e9);
            if (last_acc >= 0) check("b2b_spacing", cyc - last_acc, 10);
            last_acc = cyc;
         end
         if (done) begin
            n_done++;
            if (exp_q.size() == 0) check("b2b_unexpected_done", 1, 0);
            else check("b2b_result", {23'd0, cout, sum}, {23'd0, exp_q.pop_front()});
         end
      end
      check("b2b_drained", exp_q.size(), 0);
      check("b2b_done_count", n_done, 5);

      // WIDTH=4 exhaustive
      for (int ia = 0; ia < 16; ia++)
         for (int ib = 0; ib < 16; ib++)
            for (int ic = 0; ic < 2; ic++) begin
               a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); start4 = 1'b1;
               e5 = 5'(ia + ib + ic);
               tick();
               start4 = 1'b0;
               lat = 0;
               while (!done4 && lat < 10) begin
                  tick();
                  lat++;
               end
               check("w4_result", {27'd0, cout4, sum4}, {27'd0, e5});
               tick();
            end

      // WIDTH=1: 1+1+1
      a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      tick();
      check("w1_done_at_e1", {31'd0, done1}, 32'd1);
      check("w1_sum", {31'd0, sum1}, 32'd1);
      check("w1_cout", {31'd0, cout1}, 32'd1);
      tick();
      check("w1_ready", {31'd0, ready1}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
